// File: rtl/mips_arith_pkg.sv
// mips_arith_pkg: sequencer states and widths shared by the MIPS_CPU multiplier and divider.
package mips_arith_pkg;
  localparam int N  = 16;
  localparam int DW = 2 * N;
  localparam int AW = 2 * N + 1;
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
endpackage

// File: rtl/divisor_control.sv
// divisor_control: St/Idle/Done sequencer with the per-bit iteration down-counter.
module divisor_control
  import mips_arith_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_st,
  input  logic i_ovf,
  output logic o_load,
  output logic o_step,
  output logic o_done,
  output logic o_idle
);
  state_t r_state, w_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end
  always_comb begin
    o_idle    = r_state == IDLE;
    o_step    = r_state == DIV;
    o_done    = r_state == DONE;
    o_load    = o_idle && i_st;
    w_nxt     = o_load ? (i_ovf ? DONE : DIV) :
                o_step ? (r_cnt == '0 ? DONE : DIV) :
                o_done ? IDLE : r_state;
    w_cnt_nxt = (o_load && !i_ovf) ? CW'(N - 1) :
                (o_step && r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
  end
endmodule

// File: rtl/divisor_seq.sv
// divisor_seq: restoring divider, 2N-bit dividend by N-bit divisor, one quotient bit per clock.
module divisor_seq
  import mips_arith_pkg::*;
(
  input  logic          Clk,
  input  logic          reset,
  input  logic          St,
  input  logic [DW-1:0] Dividendo,
  input  logic [N-1:0]  Divisor,
  output logic [N-1:0]  Quociente,
  output logic [N-1:0]  Resto,
  output logic          Idle,
  output logic          Done,
  output logic          Ovf
);
  logic [AW-1:0] r_acc;
  logic [N-1:0]  r_dreg;
  logic          r_ovf;
  logic          w_load, w_step, w_ovf;
  logic [AW-1:0] w_s;
  logic [N:0]    w_t;
  divisor_control u_ctrl (
    .i_clk (Clk),
    .i_rst (reset),
    .i_st  (St),
    .i_ovf (w_ovf),
    .o_load(w_load),
    .o_step(w_step),
    .o_done(Done),
    .o_idle(Idle)
  );
  // A high half >= divisor means the quotient cannot fit in N bits; also catches divisor 0.
  assign w_ovf = Dividendo[DW-1:N] >= Divisor;
  assign w_s   = r_acc << 1;
  assign w_t   = w_s[DW:N] - {1'b0, r_dreg};
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_acc  <= '0;
      r_dreg <= '0;
      r_ovf  <= 1'b0;
    end else if (w_load) begin
      r_dreg <= Divisor;
      r_acc  <= w_ovf ? '0 : {1'b0, Dividendo};
      r_ovf  <= w_ovf;
    end else if (w_step) begin
      r_acc  <= w_t[N] ? w_s : {w_t, w_s[N-1:1], 1'b1};
    end
  end
  assign Quociente = r_acc[N-1:0];
  assign Resto     = r_acc[DW-1:N];
  assign Ovf       = r_ovf;
endmodule
